// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/HOLD handshake with instruction memory, next-PC selection and retire counting.
// Optional FETCH_ALIGN_CHECK_EN: misaligned retiring targets raise sticky AddrErr and park the unit in ERR.
module instr_fetch (
    input  logic        Clk,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic [1:0]  NPCCtrl,
    input  logic        BranchEql,
    input  logic        Zero,
    input  logic [31:0] JRTarget,
    input  logic        Retire,
    output logic [31:0] RetireCount,
    output logic        AddrErr
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000);

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, ERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] branchOffset;
    logic            branchTaken;
    logic [XLEN-1:0] npcRaw;
    logic [XLEN-1:0] npcAligned;

    assign IMemAddr = PC;

    // Next-PC select; PCPlus4 is kept registered alongside PC.
    always_comb begin
        branchOffset = {{14{Instr[15]}}, Instr[15:0], 2'b00};
        branchTaken  = BranchEql ? Zero : !Zero;
        npcRaw       = PCPlus4;
        case (NPCCtrl)
            NPC_PLUS4:  npcRaw = PCPlus4;
            NPC_BRANCH: npcRaw = branchTaken ? (PCPlus4 + branchOffset) : PCPlus4;
            NPC_JUMP:   npcRaw = {PCPlus4[31:28], Instr[25:0], 2'b00};
            default:    npcRaw = JRTarget;
        endcase
        npcAligned = npcRaw & XLEN'(32'hFFFF_FFFC);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |npcRaw[1:0];
`else
    assign AddrErr = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= FETCH;
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + XLEN'(4);
            Instr       <= '0;
            InstrValid  <= 1'b0;
            IMemReq     <= 1'b1;
            RetireCount <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            AddrErr     <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (IMemAck) begin
                        Instr      <= IMemData;
                        InstrValid <= 1'b1;
                        IMemReq    <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (Retire) begin
                        RetireCount <= RetireCount + XLEN'(1);
                        InstrValid  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            AddrErr <= 1'b1;
                            state   <= ERR;
                        end else begin
                            PC      <= npcAligned;
                            PCPlus4 <= npcAligned + XLEN'(4);
                            IMemReq <= 1'b1;
                            state   <= FETCH;
                        end
`else
                        PC      <= npcAligned;
                        PCPlus4 <= npcAligned + XLEN'(4);
                        IMemReq <= 1'b1;
                        state   <= FETCH;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                ERR: begin
                    IMemReq    <= 1'b0;
                    InstrValid <= 1'b0;
                end
`endif
                default: begin
                    state      <= FETCH;
                    IMemReq    <= 1'b1;
                    InstrValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expectations are hand-computed constants.
module tb_instr_fetch;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [1:0]  NPCCtrl = 2'b00;
    logic        BranchEql = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] JRTarget = '0;
    logic        Retire = 1'b0;
    logic [31:0] RetireCount;
    logic        AddrErr;

    int nChecks = 0;
    int nFails  = 0;

    instr_fetch dut (
        .Clk(Clk), .Reset(Reset),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
        .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
        .NPCCtrl(NPCCtrl), .BranchEql(BranchEql), .Zero(Zero), .JRTarget(JRTarget),
        .Retire(Retire), .RetireCount(RetireCount), .AddrErr(AddrErr)
    );

    always #5 Clk = ~Clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Request must be up at expAddr, then a one-cycle ack moves the unit to HOLD.
    task automatic fetchInstr(input logic [31:0] data, input logic [31:0] expAddr);
        checkEq("fetch.req", 32'(IMemReq), 32'd1);
        checkEq("fetch.addr", IMemAddr, expAddr);
        IMemAck  = 1'b1;
        IMemData = data;
        tick();
        IMemAck  = 1'b0;
        IMemData = 32'hBAD0_BAD0;
        checkEq("hold.valid", 32'(InstrValid), 32'd1);
        checkEq("hold.instr", Instr, data);
        checkEq("hold.req", 32'(IMemReq), 32'd0);
    endtask

    // Select inputs are scrambled after the retire edge to confirm they are sampled only then.
    task automatic retireInstr(input logic [1:0] ctrl, input logic beq, input logic z,
                               input logic [31:0] jr, input logic [31:0] expPc,
                               input logic [31:0] expCount, input logic expReq);
        NPCCtrl   = ctrl;
        BranchEql = beq;
        Zero      = z;
        JRTarget  = jr;
        Retire    = 1'b1;
        tick();
        Retire    = 1'b0;
        NPCCtrl   = 2'b11;
        JRTarget  = 32'hDEAD_BEEF;
        Zero      = ~z;
        checkEq("retire.pc", PC, expPc);
        checkEq("retire.pcplus4", PCPlus4, expPc + 32'd4);
        checkEq("retire.count", RetireCount, expCount);
        checkEq("retire.valid", 32'(InstrValid), 32'd0);
        checkEq("retire.req", 32'(IMemReq), 32'(expReq));
    endtask

    initial begin
        tick();
        tick();
        checkEq("rst.req", 32'(IMemReq), 32'd1);
        checkEq("rst.pc", PC, 32'h0000_3000);
        checkEq("rst.instr", Instr, 32'd0);
        checkEq("rst.valid", 32'(InstrValid), 32'd0);
        checkEq("rst.count", RetireCount, 32'd0);
        checkEq("rst.adderr", 32'(AddrErr), 32'd0);
        Reset = 1'b0;

        // Unbounded ack wait: request and address hold steady.
        for (int i = 0; i < 5; i++) begin
            tick();
            checkEq("wait.req", 32'(IMemReq), 32'd1);
            checkEq("wait.addr", IMemAddr, 32'h0000_3000);
            checkEq("wait.valid", 32'(InstrValid), 32'd0);
        end

        fetchInstr(32'h2008_0005, 32'h0000_3000);
        // Stray ack while holding must not replace the instruction.
        IMemAck  = 1'b1;
        IMemData = 32'h1234_5678;
        tick();
        IMemAck  = 1'b0;
        checkEq("hold.ignack.instr", Instr, 32'h2008_0005);
        checkEq("hold.ignack.valid", 32'(InstrValid), 32'd1);
        retireInstr(2'b00, 1'b0, 1'b0, 32'd0, 32'h0000_3004, 32'd1, 1'b1);

        fetchInstr(32'h1000_FFFF, 32'h0000_3004);
        retireInstr(2'b01, 1'b1, 1'b1, 32'd0, 32'h0000_3004, 32'd2, 1'b1);
        fetchInstr(32'h1000_FFFF, 32'h0000_3004);
        retireInstr(2'b01, 1'b1, 1'b0, 32'd0, 32'h0000_3008, 32'd3, 1'b1);

        fetchInstr(32'h0C00_0C10, 32'h0000_3008);
        retireInstr(2'b10, 1'b0, 1'b0, 32'd0, 32'h0000_3040, 32'd4, 1'b1);

        // BNE imm=+2, not equal -> taken: 0x3044 + 8.
        fetchInstr(32'h1400_0002, 32'h0000_3040);
        retireInstr(2'b01, 1'b0, 1'b0, 32'd0, 32'h0000_304C, 32'd5, 1'b1);
        // BNE with equal operands -> falls through.
        fetchInstr(32'h1400_0002, 32'h0000_304C);
        retireInstr(2'b01, 1'b0, 1'b1, 32'd0, 32'h0000_3050, 32'd6, 1'b1);

        fetchInstr(32'h03E0_0008, 32'h0000_3050);
        retireInstr(2'b11, 1'b0, 1'b0, 32'h0000_3010, 32'h0000_3010, 32'd7, 1'b1);

        fetchInstr(32'h03E0_0008, 32'h0000_3010);
`ifdef FETCH_ALIGN_CHECK_EN
        retireInstr(2'b11, 1'b0, 1'b0, 32'h0000_3012, 32'h0000_3010, 32'd8, 1'b0);
        checkEq("err.adderr", 32'(AddrErr), 32'd1);
        IMemAck = 1'b1;
        tick();
        IMemAck = 1'b0;
        checkEq("err.req", 32'(IMemReq), 32'd0);
        checkEq("err.valid", 32'(InstrValid), 32'd0);
        checkEq("err.sticky", 32'(AddrErr), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkEq("err.rst.adderr", 32'(AddrErr), 32'd0);
        checkEq("err.rst.pc", PC, 32'h0000_3000);
`else
        retireInstr(2'b11, 1'b0, 1'b0, 32'h0000_3012, 32'h0000_3010, 32'd8, 1'b1);
        checkEq("align.adderr", 32'(AddrErr), 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkEq("mid.rst.pc", PC, 32'h0000_3000);
`endif

        // Reset wins over a coincident retire in HOLD.
        fetchInstr(32'h2008_0005, 32'h0000_3000);
        Retire  = 1'b1;
        NPCCtrl = 2'b00;
        Reset   = 1'b1;
        tick();
        Retire  = 1'b0;
        Reset   = 1'b0;
        checkEq("rstret.pc", PC, 32'h0000_3000);
        checkEq("rstret.count", RetireCount, 32'd0);
        checkEq("rstret.valid", 32'(InstrValid), 32'd0);
        checkEq("rstret.req", 32'(IMemReq), 32'd1);

        // Address arithmetic wraps modulo 2^32.
        fetchInstr(32'h03E0_0008, 32'h0000_3000);
        retireInstr(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd1, 1'b1);
        fetchInstr(32'h0000_0000, 32'hFFFF_FFFC);
        retireInstr(2'b00, 1'b0, 1'b0, 32'd0, 32'h0000_0000, 32'd2, 1'b1);

        // Jump keeps the upper nibble of PC+4.
        fetchInstr(32'h03E0_0008, 32'h0000_0000);
        retireInstr(2'b11, 1'b0, 1'b0, 32'hF000_0000, 32'hF000_0000, 32'd3, 1'b1);
        fetchInstr(32'h0800_0001, 32'hF000_0000);
        retireInstr(2'b10, 1'b0, 1'b0, 32'd0, 32'hF000_0004, 32'd4, 1'b1);

        // Back-to-back: ack on the request cycle, retire on the first HOLD cycle.
        fetchInstr(32'h2008_0005, 32'hF000_0004);
        retireInstr(2'b00, 1'b0, 1'b0, 32'd0, 32'hF000_0008, 32'd5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
